// File: rtl/freq_gen.sv
// freq_gen: programmable square-wave source, frequency given in kHz.
// A restoring serial divider turns freq_khz into a half-period cycle count
// (HALF_K / freq_khz); a half-period counter toggles wave_out. New periods
// are applied only at a toggle boundary so retunes never produce runt pulses.
// Optional build macro FREQ_GEN_BURST_EN adds burst_len / burst_done: emit a
// fixed number of rising edges, then return to IDLE with wave_out low.
module freq_gen #(
    parameter int CLK_HZ = 50000000,
    parameter int HALF_K = CLK_HZ / 2000,
    parameter int DIV_W  = 16,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             enable,
    input  logic             load,
    input  logic [DIV_W-1:0] freq_khz,
`ifdef FREQ_GEN_BURST_EN
    input  logic [15:0]      burst_len,
    output logic             burst_done,
`endif
    output logic             wave_out,
    output logic             running,
    output logic             div_busy,
    output logic             load_ack
);

    localparam int IT_W = $clog2(DIV_W + 1);
    localparam logic [DIV_W-1:0] HALF_K_V = DIV_W'(HALF_K);
    localparam logic [IT_W-1:0]  IT_LAST  = IT_W'(DIV_W - 1);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RUN} state_t;

    state_t r_state, w_state_nxt;

    // divider state
    logic              r_busy;
    logic [IT_W-1:0]   r_iter;
    logic [DIV_W-1:0]  r_rem;
    logic [DIV_W-1:0]  r_dvd;   // dividend bits shift out, quotient bits shift in
    logic [DIV_W-1:0]  r_dvs;
    logic [DIV_W:0]    w_rem_sh;
    logic [DIV_W:0]    w_diff;
    logic              w_qbit;
    logic [DIV_W-1:0]  w_q_fin;
    logic [CNT_W-1:0]  w_q_clamp;

    // wave generator state
    logic              r_wave, w_wave_nxt;
    logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
    logic [CNT_W-1:0]  r_half_per, w_half_per_nxt;
    logic [CNT_W-1:0]  r_next_per, w_next_per_nxt;
    logic              r_pend, w_pend_nxt;
    logic              r_ack, w_ack_nxt;

    // control decode
    logic w_start, w_zero_ld, w_div_done, w_done_ok, w_toggle, w_abort;
    logic w_burst_end;

`ifdef FREQ_GEN_BURST_EN
    logic        r_burst_on, w_burst_on_nxt;
    logic [15:0] r_rise_left, w_rise_left_nxt;
    logic        r_bdone, w_bdone_nxt;
`endif

    // Quotient 0 means a frequency above HALF_K: fastest legal wave is a
    // 1-clock half period. Quotients wider than the counter saturate.
    function automatic logic [CNT_W-1:0] clamp_q(input logic [DIV_W-1:0] q);
        logic [DIV_W+CNT_W-1:0] qx;
        qx = {{CNT_W{1'b0}}, q};
        if (q == '0)
            clamp_q = CNT_W'(1);
        else if ((qx >> CNT_W) != '0)
            clamp_q = '1;
        else
            clamp_q = qx[CNT_W-1:0];
    endfunction

    assign w_start    = enable && load && (freq_khz != '0);
    assign w_zero_ld  = enable && load && (freq_khz == '0);
    assign w_div_done = r_busy && (r_iter == IT_LAST);
    assign w_toggle   = (r_state == S_RUN) && (r_cnt == (r_half_per - CNT_W'(1)));

`ifdef FREQ_GEN_BURST_EN
    assign w_burst_end = w_toggle && r_wave && r_burst_on && (r_rise_left == '0);
`else
    assign w_burst_end = 1'b0;
`endif

    assign w_abort   = !enable || w_zero_ld || w_burst_end;
    // A restart in the same cycle as completion discards the stale result.
    assign w_done_ok = w_div_done && !w_start && !w_abort;

    // one restoring step: shift in next dividend bit, trial-subtract divisor
    assign w_rem_sh  = {r_rem, r_dvd[DIV_W-1]};
    assign w_diff    = w_rem_sh - {1'b0, r_dvs};
    assign w_qbit    = ~w_diff[DIV_W];
    assign w_q_fin   = {r_dvd[DIV_W-2:0], w_qbit};
    assign w_q_clamp = clamp_q(w_q_fin);

    // serial divider: start/abort handling and one quotient bit per clock
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_busy <= 1'b0;
            r_iter <= '0;
            r_rem  <= '0;
            r_dvd  <= '0;
            r_dvs  <= '0;
        end else if (w_abort) begin
            r_busy <= 1'b0;
        end else if (w_start) begin
            r_busy <= 1'b1;
            r_iter <= '0;
            r_rem  <= '0;
            r_dvd  <= HALF_K_V;
            r_dvs  <= freq_khz;
        end else if (r_busy) begin
            r_rem  <= w_qbit ? w_diff[DIV_W-1:0] : w_rem_sh[DIV_W-1:0];
            r_dvd  <= w_q_fin;
            r_iter <= r_iter + IT_W'(1);
            if (r_iter == IT_LAST)
                r_busy <= 1'b0;
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            r_state <= S_IDLE;
        else
            r_state <= w_state_nxt;
    end

    // FSM next-state logic; disable, zero load and burst end all force IDLE
    always_comb begin
        w_state_nxt = r_state;
        if (w_abort) begin
            w_state_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:  if (w_start)   w_state_nxt = S_WAIT;
                S_WAIT:  if (w_done_ok) w_state_nxt = S_RUN;
                S_RUN:   w_state_nxt = S_RUN;
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    // FSM output / datapath next values
    always_comb begin
        w_wave_nxt     = r_wave;
        w_cnt_nxt      = r_cnt;
        w_half_per_nxt = r_half_per;
        w_next_per_nxt = r_next_per;
        w_pend_nxt     = r_pend;
        w_ack_nxt      = 1'b0;
`ifdef FREQ_GEN_BURST_EN
        w_burst_on_nxt  = r_burst_on;
        w_rise_left_nxt = r_rise_left;
        w_bdone_nxt     = 1'b0;
`endif
        if (w_abort) begin
            w_wave_nxt = 1'b0;
            w_cnt_nxt  = '0;
            w_pend_nxt = 1'b0;
`ifdef FREQ_GEN_BURST_EN
            w_bdone_nxt = w_burst_end && enable && !w_zero_ld;
`endif
        end else begin
            case (r_state)
                S_WAIT: begin
                    if (w_done_ok) begin
                        w_half_per_nxt = w_q_clamp;
                        w_cnt_nxt      = '0;
                        w_wave_nxt     = 1'b1;
                        w_ack_nxt      = 1'b1;
`ifdef FREQ_GEN_BURST_EN
                        if (r_burst_on)
                            w_rise_left_nxt = r_rise_left - 16'd1;
`endif
                    end
                end
                S_RUN: begin
                    if (w_toggle) begin
                        w_wave_nxt = ~r_wave;
                        w_cnt_nxt  = '0;
                        if (r_pend) begin
                            w_half_per_nxt = r_next_per;
                            w_pend_nxt     = 1'b0;
                            w_ack_nxt      = 1'b1;
                        end
`ifdef FREQ_GEN_BURST_EN
                        if (!r_wave && r_burst_on)
                            w_rise_left_nxt = r_rise_left - 16'd1;
`endif
                    end else begin
                        w_cnt_nxt = r_cnt + CNT_W'(1);
                    end
                    // retune result waits for the next toggle boundary
                    if (w_done_ok) begin
                        w_next_per_nxt = w_q_clamp;
                        w_pend_nxt     = 1'b1;
                    end
                end
                default: ;
            endcase
`ifdef FREQ_GEN_BURST_EN
            // a fresh start latches the edge budget; a retune keeps it
            if (w_start && r_state != S_RUN) begin
                w_rise_left_nxt = burst_len;
                w_burst_on_nxt  = (burst_len != '0);
            end
`endif
        end
    end

    // datapath registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wave     <= 1'b0;
            r_cnt      <= '0;
            r_half_per <= '0;
            r_next_per <= '0;
            r_pend     <= 1'b0;
            r_ack      <= 1'b0;
        end else begin
            r_wave     <= w_wave_nxt;
            r_cnt      <= w_cnt_nxt;
            r_half_per <= w_half_per_nxt;
            r_next_per <= w_next_per_nxt;
            r_pend     <= w_pend_nxt;
            r_ack      <= w_ack_nxt;
        end
    end

`ifdef FREQ_GEN_BURST_EN
    // burst edge budget and completion pulse
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_burst_on  <= 1'b0;
            r_rise_left <= '0;
            r_bdone     <= 1'b0;
        end else begin
            r_burst_on  <= w_burst_on_nxt;
            r_rise_left <= w_rise_left_nxt;
            r_bdone     <= w_bdone_nxt;
        end
    end

    assign burst_done = r_bdone;
`endif

    assign wave_out = r_wave;
    assign running  = (r_state == S_RUN);
    assign div_busy = r_busy;
    assign load_ack = r_ack;

endmodule

// File: tb/tb_freq_gen.sv
// Directed self-checking bench for freq_gen at the default 50 MHz / 16-bit
// configuration. Cycle 0 is the cycle in which load is held high; outputs
// are sampled 1 time unit after each rising edge.
`timescale 1ns/1ps
module tb_freq_gen;

    logic        clk;
    logic        reset_n;
    logic        enable;
    logic        load;
    logic [15:0] freq_khz;
    logic        wave_out, running, div_busy, load_ack;
`ifdef FREQ_GEN_BURST_EN
    logic [15:0] burst_len;
    logic        burst_done;
`endif

    int checks = 0;
    int errors = 0;
    int cyc;

    freq_gen dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .enable   (enable),
        .load     (load),
        .freq_khz (freq_khz),
`ifdef FREQ_GEN_BURST_EN
        .burst_len (burst_len),
        .burst_done(burst_done),
`endif
        .wave_out (wave_out),
        .running  (running),
        .div_busy (div_busy),
        .load_ack (load_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic advance(input int target);
        while (cyc < target) begin
            tick();
            cyc++;
        end
    endtask

    // strobe load for cycle 0; returns sampled at cycle 1
    task automatic start_load(input logic [15:0] f);
        load = 1'b1; freq_khz = f; cyc = 0;
        tick(); cyc = 1;
        load = 1'b0;
    endtask

    task automatic go_idle();
        load = 1'b1; freq_khz = 16'd0;
        tick();
        load = 1'b0;
        tick(); tick();
    endtask

    task automatic test_reset();
        reset_n = 1'b0; enable = 1'b0; load = 1'b0; freq_khz = '0;
`ifdef FREQ_GEN_BURST_EN
        burst_len = '0;
`endif
        repeat (3) @(posedge clk);
        #1;
        checks++; if (wave_out !== 1'b0) begin errors++; $display("FAIL reset_wave: got %b expected 0", wave_out); end
        checks++; if (running  !== 1'b0) begin errors++; $display("FAIL reset_running: got %b expected 0", running); end
        checks++; if (div_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", div_busy); end
        checks++; if (load_ack !== 1'b0) begin errors++; $display("FAIL reset_ack: got %b expected 0", load_ack); end
        reset_n = 1'b1;
        tick();
        enable = 1'b1;
        tick();
    endtask

    // 1 kHz start, then retune to 50 kHz at cnt=100; whole trace compared per cycle
    task automatic test_1khz_retune();
        logic ew, ea, eb, er;
        int bad, first;
        bad = 0; first = -1;
        for (int c = 0; c <= 26100; c++) begin
            if (c < 17)          ew = 1'b0;
            else if (c < 25017)  ew = 1'b1;
            else                 ew = (((c - 25017) / 500) % 2) != 0;
            ea = (c == 17) || (c == 25017);
            eb = (c >= 1 && c <= 16) || (c >= 118 && c <= 133);
            er = (c >= 17);
            if (wave_out !== ew || load_ack !== ea || div_busy !== eb || running !== er) begin
                if (first < 0) first = c;
                bad++;
            end
            load = (c == 0) || (c == 117);
            freq_khz = (c == 0) ? 16'd1 : 16'd50;
            tick();
        end
        load = 1'b0;
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL retune_trace: %0d bad cycles (first at cycle %0d), expected 0", bad, first);
        end
    endtask

    task automatic test_zero_off();
        int n;
        n = 0;
        while (wave_out !== 1'b1 && n < 1100) begin tick(); n++; end
        checks++; if (wave_out !== 1'b1) begin errors++; $display("FAIL zero_wait_high: got %b expected 1", wave_out); end
        load = 1'b1; freq_khz = 16'd0;
        tick();
        load = 1'b0;
        checks++; if (wave_out !== 1'b0) begin errors++; $display("FAIL zero_wave: got %b expected 0", wave_out); end
        checks++; if (running  !== 1'b0) begin errors++; $display("FAIL zero_running: got %b expected 0", running); end
        checks++; if (div_busy !== 1'b0) begin errors++; $display("FAIL zero_busy: got %b expected 0", div_busy); end
        tick();
    endtask

    task automatic test_clamp();
        start_load(16'd30000);
        advance(16);
        checks++; if (div_busy !== 1'b1 || wave_out !== 1'b0) begin errors++; $display("FAIL clamp_c16: busy=%b wave=%b expected 1/0", div_busy, wave_out); end
        advance(17);
        checks++; if (wave_out !== 1'b1) begin errors++; $display("FAIL clamp_c17_wave: got %b expected 1", wave_out); end
        checks++; if (load_ack !== 1'b1) begin errors++; $display("FAIL clamp_c17_ack: got %b expected 1", load_ack); end
        checks++; if (running  !== 1'b1) begin errors++; $display("FAIL clamp_c17_run: got %b expected 1", running); end
        advance(18);
        checks++; if (wave_out !== 1'b0 || load_ack !== 1'b0) begin errors++; $display("FAIL clamp_c18: wave=%b ack=%b expected 0/0", wave_out, load_ack); end
        advance(19);
        checks++; if (wave_out !== 1'b1) begin errors++; $display("FAIL clamp_c19: got %b expected 1", wave_out); end
        advance(20);
        checks++; if (wave_out !== 1'b0 || running !== 1'b1) begin errors++; $display("FAIL clamp_c20: wave=%b run=%b expected 0/1", wave_out, running); end
        go_idle();
    endtask

    task automatic test_25khz();
        start_load(16'd25);
        advance(17);
        checks++; if (wave_out !== 1'b1) begin errors++; $display("FAIL k25_rise: got %b expected 1", wave_out); end
        advance(1016);
        checks++; if (wave_out !== 1'b1) begin errors++; $display("FAIL k25_c1016: got %b expected 1", wave_out); end
        advance(1017);
        checks++; if (wave_out !== 1'b0 || load_ack !== 1'b0) begin errors++; $display("FAIL k25_c1017: wave=%b ack=%b expected 0/0", wave_out, load_ack); end
        advance(2016);
        checks++; if (wave_out !== 1'b0) begin errors++; $display("FAIL k25_c2016: got %b expected 0", wave_out); end
        advance(2017);
        checks++; if (wave_out !== 1'b1) begin errors++; $display("FAIL k25_c2017: got %b expected 1", wave_out); end
        go_idle();
    endtask

    // second load while dividing: first result dropped, latest value used
    task automatic test_back_to_back();
        start_load(16'd1);
        advance(5);
        load = 1'b1; freq_khz = 16'd25;
        tick(); cyc = 6;
        load = 1'b0;
        checks++; if (div_busy !== 1'b1) begin errors++; $display("FAIL b2b_c6_busy: got %b expected 1", div_busy); end
        advance(17);
        checks++; if (wave_out !== 1'b0 || load_ack !== 1'b0) begin errors++; $display("FAIL b2b_c17: wave=%b ack=%b expected 0/0", wave_out, load_ack); end
        advance(21);
        checks++; if (div_busy !== 1'b1 || wave_out !== 1'b0) begin errors++; $display("FAIL b2b_c21: busy=%b wave=%b expected 1/0", div_busy, wave_out); end
        advance(22);
        checks++; if (wave_out !== 1'b1 || load_ack !== 1'b1 || div_busy !== 1'b0) begin errors++; $display("FAIL b2b_c22: wave=%b ack=%b busy=%b expected 1/1/0", wave_out, load_ack, div_busy); end
        advance(1021);
        checks++; if (wave_out !== 1'b1) begin errors++; $display("FAIL b2b_c1021: got %b expected 1", wave_out); end
        advance(1022);
        checks++; if (wave_out !== 1'b0) begin errors++; $display("FAIL b2b_c1022: got %b expected 0", wave_out); end
        go_idle();
    endtask

    task automatic test_enable_abort();
        int bad;
        start_load(16'd25);
        advance(5);
        checks++; if (div_busy !== 1'b1) begin errors++; $display("FAIL en_c5_busy: got %b expected 1", div_busy); end
        enable = 1'b0;
        tick();
        checks++; if (div_busy !== 1'b0 || running !== 1'b0 || wave_out !== 1'b0) begin errors++; $display("FAIL en_abort: busy=%b run=%b wave=%b expected 0/0/0", div_busy, running, wave_out); end
        bad = 0;
        for (int i = 0; i < 30; i++) begin
            if (load_ack !== 1'b0 || wave_out !== 1'b0) bad++;
            tick();
        end
        checks++; if (bad !== 0) begin errors++; $display("FAIL en_no_ack: %0d bad cycles, expected 0", bad); end
        load = 1'b1; freq_khz = 16'd25;
        tick();
        load = 1'b0;
        checks++; if (div_busy !== 1'b0) begin errors++; $display("FAIL en_low_load: busy=%b expected 0", div_busy); end
        enable = 1'b1; load = 1'b1; freq_khz = 16'd25;
        tick();
        load = 1'b0;
        checks++; if (div_busy !== 1'b1) begin errors++; $display("FAIL en_rise_load: busy=%b expected 1", div_busy); end
        go_idle();
    endtask

    task automatic test_reset_mid_run();
        start_load(16'd25);
        advance(27);
        checks++; if (wave_out !== 1'b1 || running !== 1'b1) begin errors++; $display("FAIL rst_pre: wave=%b run=%b expected 1/1", wave_out, running); end
        reset_n = 1'b0;
        #1;
        checks++; if (wave_out !== 1'b0) begin errors++; $display("FAIL rst_async_wave: got %b expected 0", wave_out); end
        checks++; if (running  !== 1'b0) begin errors++; $display("FAIL rst_async_run: got %b expected 0", running); end
        checks++; if (div_busy !== 1'b0 || load_ack !== 1'b0) begin errors++; $display("FAIL rst_async_misc: busy=%b ack=%b expected 0/0", div_busy, load_ack); end
        #2 reset_n = 1'b1;
        tick(); tick();
        checks++; if (wave_out !== 1'b0 || running !== 1'b0) begin errors++; $display("FAIL rst_after: wave=%b run=%b expected 0/0", wave_out, running); end
    endtask

`ifdef FREQ_GEN_BURST_EN
    task automatic test_burst();
        int rises, dones, done_at;
        logic prev;
        rises = 0; dones = 0; done_at = -1; prev = 1'b0;
        burst_len = 16'd3;
        for (int c = 0; c <= 20000; c++) begin
            if (wave_out === 1'b1 && prev === 1'b0) rises++;
            if (burst_done === 1'b1) begin dones++; done_at = c; end
            prev = wave_out;
            load = (c == 0);
            freq_khz = 16'd10;
            tick();
        end
        load = 1'b0; burst_len = '0;
        checks++; if (rises !== 3) begin errors++; $display("FAIL burst_rises: got %0d expected 3", rises); end
        checks++; if (dones !== 1) begin errors++; $display("FAIL burst_done_cnt: got %0d expected 1", dones); end
        checks++; if (done_at !== 12517) begin errors++; $display("FAIL burst_done_cyc: got %0d expected 12517", done_at); end
        checks++; if (wave_out !== 1'b0 || running !== 1'b0) begin errors++; $display("FAIL burst_end: wave=%b run=%b expected 0/0", wave_out, running); end
    endtask
`endif

    initial begin
        test_reset();
        test_1khz_retune();
        test_zero_off();
        test_clamp();
        test_25khz();
        test_back_to_back();
        test_enable_abort();
`ifdef FREQ_GEN_BURST_EN
        test_burst();
`endif
        test_reset_mid_run();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/freq_gen.md
Name: freq_gen

Overview:
- Programmable square-wave source; the transmit side of the rover's frequency-counting path.
- Drives the IR beacon emitter, or loops back into the sensor input of the kHz frequency counter for self-test.
- Frequency is programmed in kHz, matching the counter's units. A serial divider converts it to a half-period cycle count; an output counter toggles wave_out.
- Retunes are glitch-free: a new period takes effect only at a toggle boundary.

Parameters:
- CLK_HZ, 50000000, system clock frequency in Hz.
- HALF_K, CLK_HZ/2000 (25000), clock cycles per half-period at 1 kHz.
- DIV_W, 16, width of freq_khz, divider quotient and divider iteration count.
- CNT_W, 16, width of the half-period counter; must hold HALF_K.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- enable  in  1  level; low forces IDLE and wave_out=0.
- load  in  1  single-cycle strobe; samples freq_khz.
- freq_khz  in  DIV_W  requested frequency in kHz; 0 means off.
- wave_out  out  1  generated square wave, 50% duty (±1 clk from truncation).
- running  out  1  high while in RUN.
- div_busy  out  1  divider computing.
- load_ack  out  1  one-cycle pulse when a new half-period becomes active.

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low (reset_n).
  - Reset values: wave_out=0, running=0, div_busy=0, load_ack=0, state=IDLE, cnt=0, half_per=0, pend=0.
- Main FSM states: IDLE, WAIT_DIV, RUN.
  - IDLE: wave_out=0. A load with enable=1 and freq_khz!=0 starts the divider and moves to WAIT_DIV.
  - WAIT_DIV: on divider done, half_per=q, cnt=0, wave_out=1, load_ack=1, and move to RUN.
  - RUN: cnt increments each clock. When cnt==half_per-1: toggle wave_out, cnt=0; if pend, then half_per=next_per, pend=0, load_ack=1.
- Divider: restoring, one quotient bit per clock, computing q = HALF_K / freq_khz.
  - load sampled at cycle 0; div_busy high for cycles 1..DIV_W; result registered at the end of cycle DIV_W.
  - From IDLE, wave_out first rises at cycle DIV_W+1 = 17.
- Quotient clamp: q==0 (freq_khz > HALF_K) clamps to 1, giving a period of 2 clocks. A quotient above CNT_W range saturates to all-ones.
- Retune in RUN: a load with nonzero freq_khz restarts the divider. On done, next_per=q and pend=1. The old period continues until the next toggle, so there is no runt pulse.
- load while div_busy: the divider restarts with the new value; latest load wins and the earlier result is discarded.
- load with freq_khz==0 (any state): abort the divider, clear pend, go to IDLE, wave_out=0 next cycle.
- enable low (any state): next cycle go to IDLE, wave_out=0, divider aborted, pend cleared. load is ignored while enable is low.
- load while enable transitions: a load in the same cycle enable is sampled high is accepted.
- reset_n asserted mid-operation: all outputs go to reset values immediately (asynchronous); no partial pulse completes.

Optional Feature:
- Macro: FREQ_GEN_BURST_EN.
- Defined: adds burst_len (in, 16) and burst_done (out, 1).
  - If burst_len!=0 at load, exactly burst_len rising edges are emitted, then wave_out returns low. On the cycle of the final falling edge: go to IDLE, burst_done=1 for one cycle.
  - burst_len==0 means continuous output.
  - A retune mid-burst keeps the remaining edge count.
- Undefined: ports absent, output is always continuous, no edge counter logic.

Test Plan:
- Reset, enable=1, load freq_khz=1 -> div_busy cycles 1..16, wave_out rises at cycle 17, then toggles every 25000 clks (period 50000); load_ack pulses once at cycle 17.
- freq_khz=25 -> half_per=1000, period 2000 clks. Feed wave_out to the frequency counter -> reads 25 (±1).
- freq_khz=30000 -> q=0 clamps to 1; wave_out toggles every clock (period 2); running=1.
- RUN at 1 kHz, load freq_khz=50 at cnt=100 -> old 25000-clk half-period completes; from that toggle on, half-periods of 500; no pulse shorter than 500 clks.
- RUN, then load freq_khz=0 -> wave_out=0 and running=0 next cycle. Separately, deassert enable mid-divide -> IDLE, div_busy=0, no load_ack.
- Assert reset_n low mid-RUN with wave_out=1 -> all outputs 0 immediately. (Burst build: burst_len=3 at 10 kHz -> exactly 3 rising edges, burst_done pulse, wave_out held low.)
